// File: rtl/flag_update_ctrl.sv
// rtl/flag_update_ctrl.sv - 6502 status-flag update controller with INT/BRK push sequencing
module flag_update_ctrl #(
  parameter int I_BIT = 2,
  parameter int B_BIT = 4,
  parameter int U_BIT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd,
  input  logic [2:0] cmd_bit,
  input  logic       cmd_val,
  input  logic [7:0] alu_result,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [7:0] operand,
  input  logic [7:0] acc,
  input  logic       is_brk,
  input  logic [7:0] flags_q,
  output logic [7:0] flag_ena,
  output logic [7:0] flag_d,
  output logic       push_valid,
  input  logic       push_ready,
  output logic [7:0] push_data,
  output logic       int_done
);

  localparam int N_BIT = 7;
  localparam int V_BIT = 6;
  localparam int Z_BIT = 1;
  localparam int C_BIT = 0;

  localparam logic [3:0] CMD_NZ     = 4'd1;
  localparam logic [3:0] CMD_NZC    = 4'd2;
  localparam logic [3:0] CMD_NVZC   = 4'd3;
  localparam logic [3:0] CMD_BIT    = 4'd4;
  localparam logic [3:0] CMD_SETCLR = 4'd5;
  localparam logic [3:0] CMD_PLP    = 4'd6;
  localparam logic [3:0] CMD_INT    = 4'd7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_WAIT = 2'd1,
    INT_PUSH = 2'd2,
    INT_SETI = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] flag_ena_q, flag_ena_d;
  logic [7:0] flag_d_q, flag_d_d;
  logic       push_valid_q, push_valid_d;
  logic [7:0] push_data_q, push_data_d;
  logic       int_done_q, int_done_d;
  logic       brk_q, brk_d;
  logic       accept;

  assign accept = cmd_valid && (state_q == IDLE);

  // Next-state and next-output computation for flag pulses and the INT sequence.
  always_comb begin
    state_d      = state_q;
    flag_ena_d   = 8'h00;
    flag_d_d     = 8'h00;
    push_valid_d = push_valid_q;
    push_data_d  = push_data_q;
    int_done_d   = 1'b0;
    brk_d        = brk_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_NZ, CMD_NZC, CMD_NVZC: begin
              flag_ena_d[N_BIT] = 1'b1;
              flag_ena_d[Z_BIT] = 1'b1;
              flag_d_d[N_BIT]   = alu_result[7];
              flag_d_d[Z_BIT]   = (alu_result == 8'h00);
              if (cmd != CMD_NZ) begin
                flag_ena_d[C_BIT] = 1'b1;
                flag_d_d[C_BIT]   = alu_c;
              end
              if (cmd == CMD_NVZC) begin
                flag_ena_d[V_BIT] = 1'b1;
                flag_d_d[V_BIT]   = alu_v;
              end
            end
            CMD_BIT: begin
              flag_ena_d[N_BIT] = 1'b1;
              flag_ena_d[V_BIT] = 1'b1;
              flag_ena_d[Z_BIT] = 1'b1;
              flag_d_d[N_BIT]   = operand[7];
              flag_d_d[V_BIT]   = operand[6];
              flag_d_d[Z_BIT]   = ((acc & operand) == 8'h00);
            end
            CMD_SETCLR: begin
              // B and U have no storage in the live register, so writes to them are dropped.
              if ((cmd_bit != 3'(B_BIT)) && (cmd_bit != 3'(U_BIT))) begin
                flag_ena_d[cmd_bit] = 1'b1;
                flag_d_d[cmd_bit]   = cmd_val;
              end
            end
            CMD_PLP: begin
              flag_ena_d        = 8'hFF;
              flag_ena_d[B_BIT] = 1'b0;
              flag_d_d          = operand;
              flag_d_d[U_BIT]   = 1'b1;
            end
            CMD_INT: begin
              state_d = INT_WAIT;
              brk_d   = is_brk;
            end
            default: begin
            end
          endcase
        end
      end
      INT_WAIT: begin
        // Any flag write accepted just before INT has landed in flags_q by now.
        push_data_d        = flags_q;
        push_data_d[U_BIT] = 1'b1;
        push_data_d[B_BIT] = brk_q;
        push_valid_d       = 1'b1;
        state_d            = INT_PUSH;
      end
      INT_PUSH: begin
        if (push_ready) begin
          push_valid_d      = 1'b0;
          flag_ena_d[I_BIT] = 1'b1;
          flag_d_d[I_BIT]   = 1'b1;
          int_done_d        = 1'b1;
          state_d           = INT_SETI;
        end
      end
      INT_SETI: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any INT sequence without writing I.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      flag_ena_q   <= 8'h00;
      flag_d_q     <= 8'h00;
      push_valid_q <= 1'b0;
      push_data_q  <= 8'h00;
      int_done_q   <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_ena_q   <= flag_ena_d;
      flag_d_q     <= flag_d_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      int_done_q   <= int_done_d;
      brk_q        <= brk_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign flag_ena   = flag_ena_q;
  assign flag_d     = flag_d_q;
  assign push_valid = push_valid_q;
  assign push_data  = push_data_q;
  assign int_done   = int_done_q;

endmodule

// File: tb/tb_flag_update_ctrl.sv
// tb/tb_flag_update_ctrl.sv - self-checking bench for flag_update_ctrl
module tb_flag_update_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd;
  logic [2:0] cmd_bit;
  logic       cmd_val;
  logic [7:0] alu_result;
  logic       alu_c;
  logic       alu_v;
  logic [7:0] operand;
  logic [7:0] acc;
  logic       is_brk;
  logic [7:0] preg;
  logic       preg_clear;
  logic [7:0] flag_ena;
  logic [7:0] flag_d;
  logic       push_valid;
  logic       push_ready;
  logic [7:0] push_data;
  logic       int_done;

  typedef struct {
    logic [7:0] ena;
    logic [7:0] d;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  flag_update_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_bit(cmd_bit), .cmd_val(cmd_val), .alu_result(alu_result),
    .alu_c(alu_c), .alu_v(alu_v), .operand(operand), .acc(acc), .is_brk(is_brk),
    .flags_q(preg), .flag_ena(flag_ena), .flag_d(flag_d), .push_valid(push_valid),
    .push_ready(push_ready), .push_data(push_data), .int_done(int_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the downstream per-bit-enable P register.
  always @(posedge clk) begin
    if (preg_clear) preg <= 8'h00;
    else            preg <= (preg & ~flag_ena) | (flag_d & flag_ena);
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input logic [3:0] c, input logic [2:0] b, input logic v,
                                 input logic [7:0] res, input logic ac, input logic av,
                                 input logic [7:0] op, input logic [7:0] a);
    exp_t r;
    logic z;
    r.ena = 8'h00;
    r.d   = 8'h00;
    z = (res == 8'h00);
    case (c)
      4'd1: begin r.ena = 8'h82; r.d = {res[7], 5'b0, z, 1'b0}; end
      4'd2: begin r.ena = 8'h83; r.d = {res[7], 5'b0, z, ac}; end
      4'd3: begin r.ena = 8'hC3; r.d = {res[7], av, 4'b0, z, ac}; end
      4'd4: begin r.ena = 8'hC2; r.d = {op[7], op[6], 4'b0, ((a & op) == 8'h00), 1'b0}; end
      4'd5: begin
        if (b != 3'd4 && b != 3'd5) begin
          r.ena = 8'h01 << b;
          r.d   = {7'b0, v} << b;
        end
      end
      4'd6: begin r.ena = 8'hEF; r.d = op | 8'h20; end
      default: begin end
    endcase
    return r;
  endfunction

  task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic v,
                       input logic [7:0] res, input logic ac, input logic av,
                       input logic [7:0] op, input logic [7:0] a, input logic brk);
    cmd_valid = 1'b1; cmd = c; cmd_bit = b; cmd_val = v; alu_result = res;
    alu_c = ac; alu_v = av; operand = op; acc = a; is_brk = brk;
    q.push_back(model(c, b, v, res, ac, av, op, a));
  endtask

  task automatic go_idle();
    cmd_valid = 1'b0; cmd = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (flag_ena !== 8'h00 || flag_d !== 8'h00 || push_valid !== 1'b0 ||
        push_data !== 8'h00 || int_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ena=%h d=%h pv=%b pd=%h done=%b want all 0",
               flag_ena, flag_d, push_valid, push_data, int_done);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || flag_ena !== 8'h00) begin
      errors++;
      $display("FAIL reset_ready got ready=%b ena=%h want 1/00", cmd_ready, flag_ena);
    end
  endtask

  task automatic test_alu();
    issue(4'd3, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    issue(4'd3, 3'd0, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    e = q.pop_front();
    checks++;
    if (flag_ena !== 8'hC3 || flag_d !== 8'h43 || flag_ena !== e.ena || flag_d !== e.d) begin
      errors++;
      $display("FAIL nvzc_zero got ena=%h d=%h want ena=C3 d=43", flag_ena, flag_d);
    end
    @(negedge clk);
    issue(4'd2, 3'd0, 1'b0, 8'hF0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = q.pop_front();
      checks++;
      if (flag_ena !== e.ena || flag_d !== e.d) begin
        errors++;
        $display("FAIL alu_%0d got ena=%h d=%h want ena=%h d=%h", i, flag_ena, flag_d, e.ena, e.d);
      end
      @(negedge clk);
      go_idle();
    end
    e = q.pop_front();
    checks++;
    if (flag_ena !== 8'h00) begin
      errors++;
      $display("FAIL alu_idle got ena=%h want 00", flag_ena);
    end
  endtask

  task automatic test_bit();
    issue(4'd4, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC0, 8'h0F, 1'b0);
    @(negedge clk);
    issue(4'd4, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 8'hFF, 1'b0);
    e = q.pop_front();
    checks++;
    if (flag_ena !== 8'hC2 || flag_d !== 8'hC2) begin
      errors++;
      $display("FAIL bit_c0 got ena=%h d=%h want ena=C2 d=C2", flag_ena, flag_d);
    end
    @(negedge clk);
    go_idle();
    e = q.pop_front();
    checks++;
    if (flag_ena !== e.ena || flag_d !== e.d) begin
      errors++;
      $display("FAIL bit_01 got ena=%h d=%h want ena=%h d=%h", flag_ena, flag_d, e.ena, e.d);
    end
    @(negedge clk);
  endtask

  task automatic test_plp_setclr();
    logic [3:0] cs [6] = '{4'd6, 4'd5, 4'd5, 4'd5, 4'd5, 4'd9};
    logic [2:0] bs [6] = '{3'd0, 3'd4, 3'd5, 3'd3, 3'd6, 3'd0};
    issue(cs[0], bs[0], 1'b1, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 5) issue(cs[i+1], bs[i+1], 1'b1, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0);
      else       go_idle();
      e = q.pop_front();
      checks++;
      if (flag_ena !== e.ena || flag_d !== e.d || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL plp_setclr_%0d got ena=%h d=%h rdy=%b want ena=%h d=%h rdy=1",
                 i, flag_ena, flag_d, cmd_ready, e.ena, e.d);
      end
      if (i == 0) begin
        checks++;
        if (flag_ena !== 8'hEF || flag_d !== 8'h30) begin
          errors++;
          $display("FAIL plp_10 got ena=%h d=%h want ena=EF d=30", flag_ena, flag_d);
        end
      end
      if (i == 1) begin
        checks++;
        if (flag_ena !== 8'h00) begin
          errors++;
          $display("FAIL setclr_b got ena=%h want 00", flag_ena);
        end
      end
    end
  endtask

  task automatic test_int();
    preg_clear = 1'b1;
    @(negedge clk);
    preg_clear = 1'b0;
    push_ready = 1'b0;
    issue(4'd5, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    issue(4'd7, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    e = q.pop_front();
    checks++;
    if (flag_ena !== 8'h01 || flag_d !== 8'h01) begin
      errors++;
      $display("FAIL int_setc got ena=%h d=%h want 01/01", flag_ena, flag_d);
    end
    @(negedge clk);
    go_idle();
    e = q.pop_front();
    checks++;
    if (flag_ena !== e.ena || cmd_ready !== 1'b0 || push_valid !== 1'b0) begin
      errors++;
      $display("FAIL int_wait got ena=%h rdy=%b pv=%b want 00/0/0", flag_ena, cmd_ready, push_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (push_valid !== 1'b1 || push_data !== 8'h31 || cmd_ready !== 1'b0 || flag_ena !== 8'h00) begin
        errors++;
        $display("FAIL int_stall_%0d got pv=%b pd=%h rdy=%b ena=%h want 1/31/0/00",
                 i, push_valid, push_data, cmd_ready, flag_ena);
      end
    end
    push_ready = 1'b1;
    @(negedge clk);
    push_ready = 1'b0;
    checks++;
    if (flag_ena !== 8'h04 || flag_d[2] !== 1'b1 || int_done !== 1'b1 ||
        push_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL int_seti got ena=%h d=%h done=%b pv=%b rdy=%b want 04/d2=1/1/0/0",
               flag_ena, flag_d, int_done, push_valid, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || int_done !== 1'b0 || flag_ena !== 8'h00 || preg !== 8'h05) begin
      errors++;
      $display("FAIL int_end got rdy=%b done=%b ena=%h p=%h want 1/0/00/05",
               cmd_ready, int_done, flag_ena, preg);
    end
    push_ready = 1'b1;
    issue(4'd7, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    go_idle();
    e = q.pop_front();
    @(negedge clk);
    checks++;
    if (push_valid !== 1'b1 || push_data !== 8'h25) begin
      errors++;
      $display("FAIL int_fast_push got pv=%b pd=%h want 1/25", push_valid, push_data);
    end
    @(negedge clk);
    checks++;
    if (int_done !== 1'b1 || flag_ena !== 8'h04) begin
      errors++;
      $display("FAIL int_fast_done got done=%b ena=%h want 1/04", int_done, flag_ena);
    end
    push_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_int_reset();
    preg_clear = 1'b1;
    @(negedge clk);
    preg_clear = 1'b0;
    issue(4'd7, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    go_idle();
    e = q.pop_front();
    repeat (2) @(negedge clk);
    checks++;
    if (push_valid !== 1'b1) begin
      errors++;
      $display("FAIL intrst_push got pv=%b want 1", push_valid);
    end
    rst = 1'b1;
    push_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (flag_ena !== 8'h00 || push_valid !== 1'b0 || push_data !== 8'h00 ||
          int_done !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL intrst_%0d got ena=%h pv=%b pd=%h done=%b rdy=%b want 0/0/00/0/1",
                 i, flag_ena, push_valid, push_data, int_done, cmd_ready);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_ready = 1'b0;
    checks++;
    if (preg[2] !== 1'b0 || int_done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL intrst_noi got p=%h done=%b rdy=%b want I=0/0/1", preg, int_done, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rs [4] = '{8'h80, 8'h00, 8'h01, 8'hFF};
    logic [3:0] cs [4] = '{4'd1, 4'd1, 4'd0, 4'd1};
    issue(cs[0], 3'd0, 1'b0, rs[0], 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) issue(cs[i+1], 3'd0, 1'b0, rs[i+1], 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
      else       go_idle();
      e = q.pop_front();
      checks++;
      if (flag_ena !== e.ena || flag_d !== e.d || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d got ena=%h d=%h rdy=%b want ena=%h d=%h rdy=1",
                 i, flag_ena, flag_d, cmd_ready, e.ena, e.d);
      end
      if (i < 2) begin
        checks++;
        if ({flag_d[7], flag_d[1]} !== ((i == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL b2b_nz_%0d got nz=%b%b", i, flag_d[7], flag_d[1]);
        end
      end
    end
  endtask

  initial begin
    preg = 8'h00; preg_clear = 1'b0; push_ready = 1'b0;
    cmd_valid = 1'b0; cmd = 4'd0; cmd_bit = 3'd0; cmd_val = 1'b0;
    alu_result = 8'h00; alu_c = 1'b0; alu_v = 1'b0; operand = 8'h00; acc = 8'h00; is_brk = 1'b0;
    test_reset();
    test_alu();
    test_bit();
    test_plp_setclr();
    test_int();
    test_int_reset();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
